// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter.
//   state_e  : sequencer states (IDLE, ACCESS, DONE)
//   PORT_IF  : index of the instruction-fetch port (port 0)
//   PORT_EX  : index of the execute/data port (port 1)
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StDone   = 2'd2
  } state_e;

  localparam int unsigned PORT_IF = 0;
  localparam int unsigned PORT_EX = 1;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way winner select.
//   req0, req1 : requests from port 0 / port 1
//   ptr        : round-robin pointer (port that wins a tie when FIXED_PRIO = 0)
//   valid      : at least one request present
//   winner     : 0 = port 0 wins, 1 = port 1 wins (meaningful only when valid)
module rr_pick2 #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic req0,
  input  logic req1,
  input  logic ptr,
  output logic valid,
  output logic winner
);

  always_comb begin
    valid = req0 | req1;
    if (req0 && req1) begin
      winner = FIXED_PRIO ? 1'b0 : ptr;
    end else begin
      // Single requester (or none): port 1 only if it alone asks.
      winner = req1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter/sequencer in front of a single-port byte memory.
// Latches one request at a time, drives the memory for one ACCESS cycle,
// then pulses the winner's ack for one DONE cycle. All outputs are registered.
//   clk, reset           : clock, synchronous active-high reset
//   pN_req/we/addr/wdata : port N request (held until pN_ack)
//   pN_ack, pN_rdata     : port N completion pulse and read result
//   gnt                  : one-hot owner of the memory (ACCESS and DONE)
//   busy                 : high whenever not idle
//   mem_*                : memory address/write data/write enable, read data in
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 8,
  parameter bit          FIXED_PRIO = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ack,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ack,
  output logic [DATA_W-1:0] p1_rdata,
  output logic [1:0]        gnt,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write_enable,
  input  logic [DATA_W-1:0] mem_read_data
);

  state_e            state_q, state_d;
  logic              ptr_q, ptr_d;  // 0 favours port 0 on a tie
  logic              win_q, win_d;  // latched winner index
  logic [1:0]        gnt_q, gnt_d;
  logic [1:0]        ack_q, ack_d;
  logic              busy_q, busy_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  logic pick_valid;
  logic pick_win;

  rr_pick2 #(
    .FIXED_PRIO(FIXED_PRIO)
  ) u_pick (
    .req0  (p0_req),
    .req1  (p1_req),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .winner(pick_win)
  );

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    win_d    = win_q;
    gnt_d    = gnt_q;
    ack_d    = ack_q;
    busy_d   = busy_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = we_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;

    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          win_d            = pick_win;
          addr_d           = pick_win ? p1_addr : p0_addr;
          wdata_d          = pick_win ? p1_wdata : p0_wdata;
          we_d             = pick_win ? p1_we : p0_we;
          gnt_d[PORT_IF]   = ~pick_win;
          gnt_d[PORT_EX]   = pick_win;
          busy_d           = 1'b1;
          state_d          = StAccess;
          // The pointer only advances when it actually settled a tie.
          if (!FIXED_PRIO && p0_req && p1_req) begin
            ptr_d = ~pick_win;
          end
        end
      end
      StAccess: begin
        // we_q still holds the latched direction during ACCESS.
        if (!we_q) begin
          if (win_q) begin
            rdata1_d = mem_read_data;
          end else begin
            rdata0_d = mem_read_data;
          end
        end
        we_d           = 1'b0;
        ack_d[PORT_IF] = ~win_q;
        ack_d[PORT_EX] = win_q;
        state_d        = StDone;
      end
      StDone: begin
        ack_d   = 2'b00;
        gnt_d   = 2'b00;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: begin
        ack_d   = 2'b00;
        gnt_d   = 2'b00;
        busy_d  = 1'b0;
        we_d    = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      ptr_q    <= 1'b0;
      win_q    <= 1'b0;
      gnt_q    <= 2'b00;
      ack_q    <= 2'b00;
      busy_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      win_q    <= win_d;
      gnt_q    <= gnt_d;
      ack_q    <= ack_d;
      busy_q   <= busy_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign p0_ack           = ack_q[PORT_IF];
  assign p1_ack           = ack_q[PORT_EX];
  assign p0_rdata         = rdata0_q;
  assign p1_rdata         = rdata1_q;
  assign gnt              = gnt_q;
  assign busy             = busy_q;
  assign mem_address      = addr_q;
  assign mem_write_data   = wdata_q;
  assign mem_write_enable = we_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: instance 0 is round-robin, instance 1 fixed priority.
// A transaction-level model predicts every output on every cycle; directed
// scenarios add literal expectations, then randomized requesters run.
module tb_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst      [2];
  logic        p0_req   [2];
  logic        p0_we    [2];
  logic [15:0] p0_addr  [2];
  logic [7:0]  p0_wdata [2];
  logic        p0_ack   [2];
  logic [7:0]  p0_rdata [2];
  logic        p1_req   [2];
  logic        p1_we    [2];
  logic [15:0] p1_addr  [2];
  logic [7:0]  p1_wdata [2];
  logic        p1_ack   [2];
  logic [7:0]  p1_rdata [2];
  logic [1:0]  gnt      [2];
  logic        busy     [2];
  logic [15:0] mem_address      [2];
  logic [7:0]  mem_write_data   [2];
  logic        mem_write_enable [2];
  logic [7:0]  mem_read_data    [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    bit [7:0] mem [65536];
    mem_arbiter #(
      .ADDR_W    (16),
      .DATA_W    (8),
      .FIXED_PRIO(g == 1)
    ) u_dut (
      .clk             (clk),
      .reset           (rst[g]),
      .p0_req          (p0_req[g]),
      .p0_we           (p0_we[g]),
      .p0_addr         (p0_addr[g]),
      .p0_wdata        (p0_wdata[g]),
      .p0_ack          (p0_ack[g]),
      .p0_rdata        (p0_rdata[g]),
      .p1_req          (p1_req[g]),
      .p1_we           (p1_we[g]),
      .p1_addr         (p1_addr[g]),
      .p1_wdata        (p1_wdata[g]),
      .p1_ack          (p1_ack[g]),
      .p1_rdata        (p1_rdata[g]),
      .gnt             (gnt[g]),
      .busy            (busy[g]),
      .mem_address     (mem_address[g]),
      .mem_write_data  (mem_write_data[g]),
      .mem_write_enable(mem_write_enable[g]),
      .mem_read_data   (mem_read_data[g])
    );
    always @(posedge clk) if (mem_write_enable[g]) mem[mem_address[g]] <= mem_write_data[g];
    assign mem_read_data[g] = mem[mem_address[g]];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int i, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d t=%0t got %h want %h", name, i, $time, act, exp);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // A granted transaction occupies the edges start, start+1, start+2:
  // memory driven after 'start', ack after 'start+1', idle after 'start+2'.
  int          ecount = 0;
  bit          m_active [2];
  int          m_start  [2];
  bit          m_win    [2];
  bit          m_we     [2];
  bit          m_ptr    [2];
  logic [15:0] m_addr   [2];
  logic [7:0]  m_wdata  [2];
  logic [7:0]  m_rd0    [2];
  logic [7:0]  m_rd1    [2];
  bit   [7:0]  ref_mem  [2][65536];

  task automatic model_step(input int i);
    bit r0, r1, w;
    // The memory sees the write enable during the access cycle, even if reset lands.
    if (m_active[i] && ecount == m_start[i] + 1 && m_we[i]) ref_mem[i][m_addr[i]] = m_wdata[i];
    if (rst[i]) begin
      m_active[i] = 0; m_ptr[i] = 0; m_we[i] = 0;
      m_addr[i] = '0; m_wdata[i] = '0; m_rd0[i] = '0; m_rd1[i] = '0;
      return;
    end
    if (m_active[i] && ecount == m_start[i] + 1 && !m_we[i]) begin
      if (m_win[i]) m_rd1[i] = ref_mem[i][m_addr[i]];
      else          m_rd0[i] = ref_mem[i][m_addr[i]];
    end
    if (!m_active[i] || ecount >= m_start[i] + 3) begin
      r0 = p0_req[i];
      r1 = p1_req[i];
      if (r0 || r1) begin
        if (r0 && r1) begin
          if (i == 1) w = 0;
          else begin w = m_ptr[i]; m_ptr[i] = ~w; end
        end else w = r1;
        m_active[i] = 1;
        m_start[i]  = ecount;
        m_win[i]    = w;
        m_we[i]     = w ? p1_we[i] : p0_we[i];
        m_addr[i]   = w ? p1_addr[i] : p0_addr[i];
        m_wdata[i]  = w ? p1_wdata[i] : p0_wdata[i];
      end
    end
  endtask

  always @(posedge clk) begin
    ecount++;
    for (int i = 0; i < 2; i++) model_step(i);
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int d;
      bit own, drv, ack;
      d   = ecount - m_start[i];
      own = m_active[i] && d <= 1;
      drv = m_active[i] && d == 0;
      ack = m_active[i] && d == 1;
      chk("gnt", i, 16'(gnt[i]), own ? (m_win[i] ? 16'd2 : 16'd1) : 16'd0);
      chk("busy", i, 16'(busy[i]), 16'(own));
      chk("mem_we", i, 16'(mem_write_enable[i]), 16'(drv && m_we[i]));
      chk("mem_addr", i, mem_address[i], m_addr[i]);
      chk("mem_wdata", i, 16'(mem_write_data[i]), 16'(m_wdata[i]));
      chk("p0_ack", i, 16'(p0_ack[i]), 16'(ack && !m_win[i]));
      chk("p1_ack", i, 16'(p1_ack[i]), 16'(ack && m_win[i]));
      chk("p0_rdata", i, 16'(p0_rdata[i]), 16'(m_rd0[i]));
      chk("p1_rdata", i, 16'(p1_rdata[i]), 16'(m_rd1[i]));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input int port, input bit req, input bit we,
                         input logic [15:0] a, input logic [7:0] wd);
    if (port == 0) begin
      p0_req[i] = req; p0_we[i] = we; p0_addr[i] = a; p0_wdata[i] = wd;
    end else begin
      p1_req[i] = req; p1_we[i] = we; p1_addr[i] = a; p1_wdata[i] = wd;
    end
  endtask

  task automatic wait_ack(input int i, input int port, output int at);
    at = -1;
    for (int k = 0; k < 12; k++) begin
      step();
      if ((port == 0) ? p0_ack[i] : p1_ack[i]) begin
        at = ecount;
        break;
      end
    end
    checks++;
    if (at < 0) begin
      errors++;
      $display("FAIL ack_timeout inst%0d port%0d t=%0t got no ack want ack", i, port, $time);
    end
  endtask

  initial begin
    int a0, a1, n0, n1, t0;
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1;
      set_req(i, 0, 0, 0, '0, '0);
      set_req(i, 1, 0, 0, '0, '0);
    end

    // 1: reset, then p0 write 0x0000 <- 0xAA
    step(); step();
    rst[0] = 0; rst[1] = 0;
    chk("rst_gnt", 0, 16'(gnt[0]), 16'd0);
    chk("rst_busy", 0, 16'(busy[0]), 16'd0);
    set_req(0, 0, 1, 1, 16'h0000, 8'hAA);
    t0 = ecount;
    step();
    chk("s1_gnt", 0, 16'(gnt[0]), 16'd1);
    chk("s1_we", 0, 16'(mem_write_enable[0]), 16'd1);
    chk("s1_addr", 0, mem_address[0], 16'h0000);
    chk("s1_wdata", 0, 16'(mem_write_data[0]), 16'h00AA);
    step();
    chk("s1_we_off", 0, 16'(mem_write_enable[0]), 16'd0);
    chk("s1_ack", 0, 16'(p0_ack[0]), 16'd1);
    chk("s1_latency", 0, 16'(ecount - t0), 16'd2);
    set_req(0, 0, 0, 0, '0, '0);
    step();
    chk("s1_ack_off", 0, 16'(p0_ack[0]), 16'd0);

    // 2: p1 read 0x0000
    set_req(0, 1, 1, 0, 16'h0000, '0);
    step();
    chk("s2_gnt", 0, 16'(gnt[0]), 16'd2);
    chk("s2_we", 0, 16'(mem_write_enable[0]), 16'd0);
    wait_ack(0, 1, a1);
    chk("s2_p1_rdata", 0, 16'(p1_rdata[0]), 16'h00AA);
    chk("s2_p0_rdata", 0, 16'(p0_rdata[0]), 16'h0000);
    set_req(0, 1, 0, 0, '0, '0);
    step();

    // 3: simultaneous p0 write 0x0001 <- 0xBB and p1 read 0x0001
    set_req(0, 0, 1, 1, 16'h0001, 8'hBB);
    set_req(0, 1, 1, 0, 16'h0001, '0);
    step();
    chk("s3_gnt", 0, 16'(gnt[0]), 16'd1);
    wait_ack(0, 0, a0);
    set_req(0, 0, 0, 0, '0, '0);
    wait_ack(0, 1, a1);
    chk("s3_gap", 0, 16'(a1 - a0), 16'd3);
    chk("s3_rdata", 0, 16'(p1_rdata[0]), 16'h00BB);
    set_req(0, 1, 0, 0, '0, '0);
    step();
    set_req(0, 0, 1, 0, 16'h0000, '0);
    set_req(0, 1, 1, 0, 16'h0001, '0);
    step();
    chk("s3b_gnt", 0, 16'(gnt[0]), 16'd2);
    wait_ack(0, 1, a1);
    set_req(0, 1, 0, 0, '0, '0);
    wait_ack(0, 0, a0);
    chk("s3b_gap", 0, 16'(a0 - a1), 16'd3);
    chk("s3b_rdata", 0, 16'(p0_rdata[0]), 16'h00AA);
    set_req(0, 0, 0, 0, '0, '0);
    step();

    // 4: fixed priority instance, both ports requesting continuously
    set_req(1, 0, 1, 1, 16'h0000, 8'hAA);
    wait_ack(1, 0, a0);
    set_req(1, 0, 0, 0, '0, '0);
    step();
    set_req(1, 0, 1, 0, 16'h0000, '0);
    set_req(1, 1, 1, 0, 16'h0001, '0);
    n0 = 0; n1 = 0;
    for (int k = 0; k < 15; k++) begin
      step();
      if (p0_ack[1]) begin
        n0++;
        chk("s4_rdata", 1, 16'(p0_rdata[1]), 16'h00AA);
      end
      if (p1_ack[1]) n1++;
    end
    chk("s4_p0_acks", 1, 16'(n0), 16'd5);
    chk("s4_p1_acks", 1, 16'(n1), 16'd0);
    set_req(1, 0, 0, 0, '0, '0);
    wait_ack(1, 1, a1);
    chk("s4_p1_rdata", 1, 16'(p1_rdata[1]), 16'h0000);
    set_req(1, 1, 0, 0, '0, '0);
    step();

    // 5: p1 write 0x0002 <- 0xCC, reset during ACCESS
    set_req(0, 1, 1, 1, 16'h0002, 8'hCC);
    step();
    chk("s5_we", 0, 16'(mem_write_enable[0]), 16'd1);
    rst[0] = 1;
    step();
    rst[0] = 0;
    set_req(0, 1, 0, 0, '0, '0);
    chk("s5_gnt", 0, 16'(gnt[0]), 16'd0);
    chk("s5_busy", 0, 16'(busy[0]), 16'd0);
    chk("s5_we_off", 0, 16'(mem_write_enable[0]), 16'd0);
    chk("s5_addr", 0, mem_address[0], 16'h0000);
    chk("s5_p0_rdata", 0, 16'(p0_rdata[0]), 16'h0000);
    n1 = 0;
    for (int k = 0; k < 4; k++) begin
      if (p1_ack[0]) n1++;
      step();
    end
    chk("s5_no_ack", 0, 16'(n1), 16'd0);
    set_req(0, 0, 1, 0, 16'h0002, '0);
    wait_ack(0, 0, a0);
    set_req(0, 0, 0, 0, '0, '0);
    step();

    // 6: p0 holds req across ack with a new address
    set_req(0, 0, 1, 0, 16'h0000, '0);
    wait_ack(0, 0, a0);
    chk("s6_rd1", 0, 16'(p0_rdata[0]), 16'h00AA);
    set_req(0, 0, 1, 0, 16'h0001, '0);
    wait_ack(0, 0, a1);
    chk("s6_gap", 0, 16'(a1 - a0), 16'd3);
    chk("s6_rd2", 0, 16'(p0_rdata[0]), 16'h00BB);
    set_req(0, 0, 0, 0, '0, '0);
    step();

    // Randomized requesters on both instances
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 2; i++) begin
        rst[i] = ($urandom_range(299) == 0);
        for (int p = 0; p < 2; p++) begin
          bit req, ack;
          req = (p == 0) ? p0_req[i] : p1_req[i];
          ack = (p == 0) ? p0_ack[i] : p1_ack[i];
          if (req && ack) begin
            if ($urandom_range(1) == 0) set_req(i, p, 0, 0, '0, '0);
            else set_req(i, p, 1, 1'($urandom_range(1)), 16'($urandom_range(7)),
                         8'($urandom_range(255)));
          end else if (!req && $urandom_range(2) == 0) begin
            set_req(i, p, 1, 1'($urandom_range(1)), 16'($urandom_range(7)),
                    8'($urandom_range(255)));
          end
        end
      end
      step();
    end
    for (int i = 0; i < 2; i++) begin
      rst[i] = 0;
      set_req(i, 0, 0, 0, '0, '0);
      set_req(i, 1, 0, 0, '0, '0);
    end
    repeat (4) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
